// File: rtl/multi_btn_debounce.sv
// Multi-channel button debouncer: 2-flop sync, shared sample tick, STABLE_N-deep history per channel.
// Optional long-press detection is enabled by defining DEBOUNCE_LONG_PRESS_EN.
module multi_btn_debounce #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned TICK_DIV   = 100_000,
  parameter int unsigned STABLE_N   = 8,
  parameter int unsigned LONG_TICKS = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [N_CH-1:0]                sync1_q, sync2_q;
  logic [CntW-1:0]                cnt_q, cnt_d;
  logic                           tick;
  logic [N_CH-1:0][STABLE_N-1:0]  hist_q, hist_d;
  logic [N_CH-1:0]                level_q, level_d;
  logic [N_CH-1:0]                rise_q, rise_d;
  logic [N_CH-1:0]                fall_q, fall_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Level only moves when the freshly shifted history is unanimous.
  always_comb begin
    hist_d  = hist_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    if (tick) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        hist_d[i] = {hist_q[i][STABLE_N-2:0], sync2_q[i]};
        if ((&hist_d[i]) && !level_q[i]) begin
          level_d[i] = 1'b1;
          rise_d[i]  = 1'b1;
        end else if (!(|hist_d[i]) && level_q[i]) begin
          level_d[i] = 1'b0;
          fall_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      hist_q  <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_TICKS);

  logic [N_CH-1:0][HoldW-1:0] hold_q, hold_d;
  logic [N_CH-1:0]            long_q, long_d;

  // Counter saturates at LONG_TICKS so the pulse fires once; it re-arms when level drops.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (!level_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] != HoldMax)) begin
        hold_d[i] = hold_q[i] + 1'b1;
        long_d[i] = (hold_d[i] == HoldMax);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= '0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = '0;
`endif

endmodule
